// File: rtl/fir_systolic_cfg.sv
// fir_systolic_cfg -- transposed-systolic FIR with valid-qualified streaming,
// double-buffered runtime coefficients, rounded/scaled output and sync flush.
//
// Optional feature macro: FIR_OUT_SAT_EN
//   defined   : out-of-range results saturate to the output range, out_sat flags it
//   undefined : results wrap to DATA_OUT_WIDTH bits, out_sat stays 0
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous active-high reset
//   in_valid    data_in accepted this cycle
//   data_in     signed input sample
//   clear       synchronous flush of sample/accumulator pipeline (overrides in_valid)
//   coef_wr_en  write coef_wdata into the shadow bank at coef_addr
//   coef_addr   tap index; indices >= TAP_COUNT are ignored
//   coef_wdata  signed coefficient
//   coef_swap   exchange active and shadow banks
//   out_valid   data_out valid this cycle
//   data_out    signed filtered, scaled sample
//   out_sat     data_out was clipped this cycle
module fir_systolic_cfg #(
   parameter int DATA_IN_WIDTH  = 16,
   parameter int TAP_WIDTH      = 32,
   parameter int TAP_COUNT      = 102,
   parameter int DATA_OUT_WIDTH = 32,
   parameter int OUT_SHIFT      = 31
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               in_valid,
   input  logic signed [DATA_IN_WIDTH-1:0]    data_in,
   input  logic                               clear,
   input  logic                               coef_wr_en,
   input  logic [$clog2(TAP_COUNT)-1:0]       coef_addr,
   input  logic signed [TAP_WIDTH-1:0]        coef_wdata,
   input  logic                               coef_swap,
   output logic                               out_valid,
   output logic signed [DATA_OUT_WIDTH-1:0]   data_out,
   output logic                               out_sat
);

   localparam int ACC_WIDTH = DATA_IN_WIDTH + TAP_WIDTH + $clog2(TAP_COUNT);
   // Width that holds both the rounded result and the output range.
   localparam int RW = (ACC_WIDTH + 1 > DATA_OUT_WIDTH) ? ACC_WIDTH + 1 : DATA_OUT_WIDTH;

   logic signed [TAP_WIDTH-1:0]      bank0    [TAP_COUNT];
   logic signed [TAP_WIDTH-1:0]      bank1    [TAP_COUNT];
   logic signed [TAP_WIDTH-1:0]      coef_act [TAP_COUNT];
   logic                             bank_sel;          // 0: bank0 active, 1: bank1 active

   logic signed [DATA_IN_WIDTH-1:0]  x_r;
   logic                             v_r;
   logic signed [ACC_WIDTH-1:0]      acc  [1:TAP_COUNT-1];
   logic signed [ACC_WIDTH-1:0]      prod [TAP_COUNT];
   logic signed [ACC_WIDTH-1:0]      y;
   logic signed [ACC_WIDTH:0]        r;
   logic signed [RW-1:0]             r_full;
   logic signed [DATA_OUT_WIDTH-1:0] data_next;
   logic                             sat_next;

   // Active coefficients and full-precision products (operands sign-extended first).
   always_comb begin
      for (int unsigned j = 0; j < TAP_COUNT; j++) begin
         coef_act[j] = bank_sel ? bank1[j] : bank0[j];
         prod[j]     = ACC_WIDTH'(x_r) * ACC_WIDTH'(coef_act[j]);
      end
      y = acc[1] + prod[0];
   end

   generate
      if (OUT_SHIFT > 0) begin : g_round
         localparam logic signed [ACC_WIDTH:0] RND = (ACC_WIDTH + 1)'(1) <<< (OUT_SHIFT - 1);
         always_comb r = ((ACC_WIDTH + 1)'(y) + RND) >>> OUT_SHIFT;
      end else begin : g_noround
         always_comb r = (ACC_WIDTH + 1)'(y);
      end
   endgenerate

   always_comb r_full = RW'(r);

`ifdef FIR_OUT_SAT_EN
   localparam logic signed [RW-1:0] OUT_MAX = RW'({1'b0, {(DATA_OUT_WIDTH-1){1'b1}}});
   localparam logic signed [RW-1:0] OUT_MIN = ~OUT_MAX;

   always_comb begin
      sat_next  = 1'b0;
      data_next = DATA_OUT_WIDTH'(r_full);
      if (r_full > OUT_MAX) begin
         sat_next  = 1'b1;
         data_next = DATA_OUT_WIDTH'(OUT_MAX);
      end else if (r_full < OUT_MIN) begin
         sat_next  = 1'b1;
         data_next = DATA_OUT_WIDTH'(OUT_MIN);
      end
   end
`else
   always_comb begin
      sat_next  = 1'b0;
      data_next = DATA_OUT_WIDTH'(r_full);
   end
`endif

   // Coefficient banks: writes always target the pre-edge shadow bank, so a
   // write coinciding with a swap lands in the bank that becomes active.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned j = 0; j < TAP_COUNT; j++) begin
            bank0[j] <= '0;
            bank1[j] <= '0;
         end
         bank_sel <= 1'b0;
      end else begin
         if (coef_wr_en && (int'(coef_addr) < TAP_COUNT)) begin
            if (bank_sel) bank0[coef_addr] <= coef_wdata;
            else          bank1[coef_addr] <= coef_wdata;
         end
         if (coef_swap) bank_sel <= ~bank_sel;
      end
   end

   // Stage 1: input register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         x_r <= '0;
         v_r <= 1'b0;
      end else if (clear) begin
         x_r <= '0;
         v_r <= 1'b0;
      end else if (in_valid) begin
         x_r <= data_in;
         v_r <= 1'b1;
      end else begin
         v_r <= 1'b0;
      end
   end

   // Stage 2: transposed accumulator chain and output register; the chain
   // only advances on valid samples so gaps leave the partial sums intact.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned j = 1; j < TAP_COUNT; j++) acc[j] <= '0;
         out_valid <= 1'b0;
         data_out  <= '0;
         out_sat   <= 1'b0;
      end else if (clear) begin
         for (int unsigned j = 1; j < TAP_COUNT; j++) acc[j] <= '0;
         out_valid <= 1'b0;
         out_sat   <= 1'b0;
      end else if (v_r) begin
         for (int unsigned j = 1; j < TAP_COUNT - 1; j++) acc[j] <= acc[j+1] + prod[j];
         acc[TAP_COUNT-1] <= prod[TAP_COUNT-1];
         out_valid <= 1'b1;
         data_out  <= data_next;
         out_sat   <= sat_next;
      end else begin
         out_valid <= 1'b0;
         out_sat   <= 1'b0;
      end
   end

endmodule
